// File: rtl/cb_segmenter.sv
// cb_segmenter: consumer end of the code-block size FIFO.
// Pops one {C_plus, C_minus, filler} descriptor per transport block and slices
// the TB byte stream into code blocks: filler (block 0 only), data, then reserved
// CRC slots when the TB splits into two blocks. All bytes leave through
// a single output register that holds steady under backpressure.
// Optional build macro: CBSEG_STATS_EN adds the blk_cnt / err_cnt statistics ports.

module cb_segmenter #(
  parameter int         K_PLUS    = 768,
  parameter int         K_MINUS   = 132,
  parameter int         CRC_BYTES = 3,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        desc_empty,
  output logic        desc_rd,
  input  logic [19:0] desc_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sob,
  output logic        out_eob,
  output logic        out_fill,
  output logic        out_crc,
  output logic        out_klarge,
  output logic        desc_err
`ifdef CBSEG_STATS_EN
  ,
  output logic [15:0] blk_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [9:0] KP   = 10'(K_PLUS);
  localparam logic [9:0] KM   = 10'(K_MINUS);
  localparam logic [9:0] CRCL = 10'(CRC_BYTES);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, FILL, DATA, CRC, NEXT} state_t;

  state_t      state_q, state_d;
  logic [19:0] desc_q, desc_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  data_len_q, data_len_d;
  logic        klarge_q, klarge_d;
  logic        blk1_large_q, blk1_large_d;
  logic        two_blk_q, two_blk_d;
  logic        blk_idx_q, blk_idx_d;
  logic        first_q, first_d;

  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_sob_q, out_sob_d;
  logic        out_eob_q, out_eob_d;
  logic        out_fill_q, out_fill_d;
  logic        out_crc_q, out_crc_d;
  logic        out_klarge_q, out_klarge_d;

  // Descriptor decode; only meaningful while the latched descriptor is in LOAD.
  // The K_MINUS block always goes first, so block 0 is large only when C_minus=0.
  logic [1:0]  c_plus, c_minus;
  logic [15:0] filler;
  logic [2:0]  c_sum;
  logic        first_large;
  logic [9:0]  crc_len, blk0_room, blk0_data, blk1_data;
  logic        reject;

  assign c_plus      = desc_q[19:18];
  assign c_minus     = desc_q[17:16];
  assign filler      = desc_q[15:0];
  assign c_sum       = {1'b0, c_plus} + {1'b0, c_minus};
  assign first_large = (c_minus == 2'd0);
  assign crc_len     = (c_sum == 3'd2) ? CRCL : 10'd0;
  assign blk0_room   = (first_large ? KP : KM) - crc_len;
  assign reject      = (c_sum == 3'd0) || (c_sum > 3'd2) || (filler >= {6'd0, blk0_room});
  assign blk0_data   = blk0_room - filler[9:0];
  assign blk1_data   = (blk1_large_q ? KP : KM) - CRCL;

  // Byte production: a byte enters the output register only when it is free or
  // being drained this cycle; DATA additionally needs a valid input byte.
  logic adv, emit_fill, emit_data, emit_crc, emit;
  logic seg_last, blocks_remain, blk_end, start_blk1;

  assign adv           = !out_valid_q || out_ready;
  assign emit_fill     = (state_q == FILL) && adv;
  assign emit_data     = (state_q == DATA) && adv && in_valid;
  assign emit_crc      = (state_q == CRC) && adv;
  assign emit          = emit_fill || emit_data || emit_crc;
  assign seg_last      = (cnt_q == 10'd1);
  assign blocks_remain = two_blk_q && !blk_idx_q;
  assign blk_end       = seg_last && (emit_crc || (emit_data && !two_blk_q));
  // Block 1 starts straight from the last CRC byte of block 0 so the stream
  // stays gapless; NEXT only bridges the final block back to IDLE.
  assign start_blk1    = (emit_crc && seg_last && blocks_remain) ||
                         ((state_q == NEXT) && blocks_remain);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      desc_q       <= '0;
      cnt_q        <= '0;
      data_len_q   <= '0;
      klarge_q     <= 1'b0;
      blk1_large_q <= 1'b0;
      two_blk_q    <= 1'b0;
      blk_idx_q    <= 1'b0;
      first_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sob_q    <= 1'b0;
      out_eob_q    <= 1'b0;
      out_fill_q   <= 1'b0;
      out_crc_q    <= 1'b0;
      out_klarge_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      cnt_q        <= cnt_d;
      data_len_q   <= data_len_d;
      klarge_q     <= klarge_d;
      blk1_large_q <= blk1_large_d;
      two_blk_q    <= two_blk_d;
      blk_idx_q    <= blk_idx_d;
      first_q      <= first_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sob_q    <= out_sob_d;
      out_eob_q    <= out_eob_d;
      out_fill_q   <= out_fill_d;
      out_crc_q    <= out_crc_d;
      out_klarge_q <= out_klarge_d;
    end
  end

  // Next-state logic: segments advance on the last byte of each segment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!desc_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        if (reject)              state_d = IDLE;
        else if (filler != 16'd0) state_d = FILL;
        else                      state_d = DATA;
      end
      FILL:  if (emit_fill && seg_last) state_d = DATA;
      DATA:  if (emit_data && seg_last) state_d = two_blk_q ? CRC : NEXT;
      CRC:   if (emit_crc && seg_last) state_d = blocks_remain ? DATA : NEXT;
      NEXT:  state_d = blocks_remain ? DATA : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, block bookkeeping and the output register contents.
  always_comb begin
    desc_d       = desc_q;
    cnt_d        = cnt_q;
    data_len_d   = data_len_q;
    klarge_d     = klarge_q;
    blk1_large_d = blk1_large_q;
    two_blk_d    = two_blk_q;
    blk_idx_d    = blk_idx_q;
    first_d      = first_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sob_d    = out_sob_q;
    out_eob_d    = out_eob_q;
    out_fill_d   = out_fill_q;
    out_crc_d    = out_crc_q;
    out_klarge_d = out_klarge_q;

    if (state_q == FETCH) desc_d = desc_data;

    if ((state_q == LOAD) && !reject) begin
      klarge_d     = first_large;
      blk1_large_d = (c_plus != 2'd0);
      two_blk_d    = (c_sum == 3'd2);
      blk_idx_d    = 1'b0;
      first_d      = 1'b1;
      data_len_d   = blk0_data;
      cnt_d        = (filler != 16'd0) ? filler[9:0] : blk0_data;
    end

    if (emit_fill) cnt_d = seg_last ? data_len_q : cnt_q - 10'd1;
    if (emit_data) cnt_d = seg_last ? (two_blk_q ? CRCL : 10'd0) : cnt_q - 10'd1;
    if (emit_crc)  cnt_d = seg_last ? 10'd0 : cnt_q - 10'd1;
    if (emit)      first_d = 1'b0;

    if (start_blk1) begin
      blk_idx_d = 1'b1;
      klarge_d  = blk1_large_q;
      cnt_d     = blk1_data;
      first_d   = 1'b1;
    end

    if (emit) begin
      out_valid_d  = 1'b1;
      out_data_d   = emit_data ? in_data : FILL_BYTE;
      out_sob_d    = first_q;
      out_eob_d    = blk_end;
      out_fill_d   = emit_fill;
      out_crc_d    = emit_crc;
      out_klarge_d = klarge_q;
    end else if (adv) begin
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_sob_d    = 1'b0;
      out_eob_d    = 1'b0;
      out_fill_d   = 1'b0;
      out_crc_d    = 1'b0;
      out_klarge_d = 1'b0;
    end
  end

  // FSM-driven handshake outputs; the FIFO read is held off during reset so
  // a queued descriptor is never popped and then lost.
  always_comb begin
    desc_rd  = reset_n && (state_q == IDLE) && !desc_empty;
    desc_err = (state_q == LOAD) && reject;
    in_ready = (state_q == DATA) && adv;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sob    = out_sob_q;
  assign out_eob    = out_eob_q;
  assign out_fill   = out_fill_q;
  assign out_crc    = out_crc_q;
  assign out_klarge = out_klarge_q;

`ifdef CBSEG_STATS_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Count accepted block ends (wrapping) and rejected descriptors (saturating).
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    err_cnt_d = err_cnt_q;
    if (out_valid_q && out_ready && out_eob_q) blk_cnt_d = blk_cnt_q + 16'd1;
    if (desc_err && (err_cnt_q != 8'hFF))      err_cnt_d = err_cnt_q + 8'd1;
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blk_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_cb_segmenter.sv
// tb_cb_segmenter: directed, table-driven bench for cb_segmenter with a size
// FIFO model (q valid one cycle after read) and a TB byte source queue.

module tb_cb_segmenter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        desc_empty;
  logic        desc_rd;
  logic [19:0] desc_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sob, out_eob, out_fill, out_crc, out_klarge;
  logic        desc_err;
`ifdef CBSEG_STATS_EN
  logic [15:0] blk_cnt;
  logic [7:0]  err_cnt;
`endif

  cb_segmenter dut (
    .clk(clk), .reset_n(reset_n),
    .desc_empty(desc_empty), .desc_rd(desc_rd), .desc_data(desc_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob), .out_fill(out_fill),
    .out_crc(out_crc), .out_klarge(out_klarge), .desc_err(desc_err)
`ifdef CBSEG_STATS_EN
    , .blk_cnt(blk_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       sob;
    logic       eob;
    logic       fill;
    logic       crc;
    logic       klarge;
  } obyte_t;

  typedef struct {
    logic [19:0] desc;
    bit          stall;
    bit          exp_err;
    int          nblk;
    int          fill0;
    int          data0;
    int          crc0;
    bit          large0;
    int          data1;
    int          crc1;
    bit          large1;
    int          consumed;
  } vec_t;

  vec_t        vecs[11];
  logic [19:0] desc_fifo[$];
  logic [7:0]  in_q[$];
  logic [7:0]  sent_q[$];
  obyte_t      got_q[$];
  obyte_t      exp_q[$];
  logic [19:0] pend;
  bit          pend_v;
  bit          stall_mode;
  bit          prev_stall;
  bit          seen_first;
  obyte_t      prev_rec;
  int          consumed, err_pulses, in_ready_cnt, stall_err, gap_cycles;
  int          tests, fails;

  function automatic obyte_t mkByte(logic [7:0] d, logic s, logic e, logic f, logic c, logic k);
    obyte_t r;
    r.data = d; r.sob = s; r.eob = e; r.fill = f; r.crc = c; r.klarge = k;
    return r;
  endfunction

  function automatic obyte_t curRec();
    return mkByte(out_data, out_sob, out_eob, out_fill, out_crc, out_klarge);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs for the coming cycle (called just after a rising edge).
  task automatic applyStimulus();
    desc_empty = (desc_fifo.size() == 0);
    if (pend_v) begin
      desc_data = pend;
      pend_v    = 1'b0;
    end
    out_ready = stall_mode ? ~out_ready : 1'b1;
    if (in_q.size() > 0 && (!stall_mode || $urandom_range(0, 2) != 0)) begin
      in_valid = 1'b1;
      in_data  = in_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  // Observe one cycle mid-period, then advance past the next rising edge.
  task automatic runCycle();
    @(negedge clk);
    if (prev_stall && (!out_valid || curRec() != prev_rec)) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_rec   = curRec();
    if (out_valid) seen_first = 1'b1;
    else if (seen_first && got_q.size() < exp_q.size()) gap_cycles++;
    if (out_valid && out_ready) got_q.push_back(curRec());
    if (in_valid && in_ready) begin
      void'(in_q.pop_front());
      consumed++;
    end
    if (in_ready) in_ready_cnt++;
    if (desc_err) err_pulses++;
    if (desc_rd && desc_fifo.size() > 0) begin
      pend   = desc_fifo.pop_front();
      pend_v = 1'b1;
    end
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic runVector(input vec_t v, input int idx, input bit push_desc);
    int cyc, mism, nf, nd, nc, tot, di, first_bad;
    bit lg;
    logic [7:0] b;
    exp_q.delete(); got_q.delete(); sent_q.delete();
    consumed = 0; err_pulses = 0; in_ready_cnt = 0; stall_err = 0; gap_cycles = 0;
    seen_first = 1'b0; prev_stall = 1'b0;
    for (int i = 0; i < v.consumed; i++) begin
      b = 8'(idx * 53 + i * 7 + 1);
      in_q.push_back(b);
      sent_q.push_back(b);
    end
    di = 0;
    for (int blk = 0; blk < v.nblk; blk++) begin
      nf  = (blk == 0) ? v.fill0 : 0;
      nd  = (blk == 0) ? v.data0 : v.data1;
      nc  = (blk == 0) ? v.crc0 : v.crc1;
      lg  = (blk == 0) ? v.large0 : v.large1;
      tot = nf + nd + nc;
      for (int p = 0; p < tot; p++) begin
        if (p < nf)           exp_q.push_back(mkByte(8'h00, p == 0, p == tot - 1, 1'b1, 1'b0, lg));
        else if (p < nf + nd) exp_q.push_back(mkByte(sent_q[di++], p == 0, p == tot - 1, 1'b0, 1'b0, lg));
        else                  exp_q.push_back(mkByte(8'h00, p == 0, p == tot - 1, 1'b0, 1'b1, lg));
      end
    end
    stall_mode = v.stall;
    if (push_desc) desc_fifo.push_back(v.desc);
    applyStimulus();
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 6000) begin
      runCycle();
      cyc++;
    end
    repeat (8) runCycle();
    mism = 0; first_bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    if (first_bad >= 0)
      $display("[TB] v%0d first difference at byte %0d: dut %h model %h",
               idx, first_bad, got_q[first_bad], exp_q[first_bad]);
    checkOutput($sformatf("v%0d byte count", idx), got_q.size(), exp_q.size());
    checkOutput($sformatf("v%0d byte content errors", idx), mism, 0);
    checkOutput($sformatf("v%0d bytes consumed", idx), consumed, v.consumed);
    checkOutput($sformatf("v%0d desc_err pulses", idx), err_pulses, v.exp_err ? 1 : 0);
    if (v.exp_err) checkOutput($sformatf("v%0d in_ready cycles", idx), in_ready_cnt, 0);
    if (v.stall) checkOutput($sformatf("v%0d stall hold errors", idx), stall_err, 0);
    else         checkOutput($sformatf("v%0d gap cycles", idx), gap_cycles, 0);
    stall_mode = 1'b0;
  endtask

  initial begin
    // desc, stall, err, nblk, fill0, data0, crc0, large0, data1, crc1, large1, consumed
    vecs[0]  = '{20'h10020, 0, 0, 1,  32, 100, 0, 0,   0, 0, 0,  100};
    vecs[1]  = '{20'h5005E, 0, 0, 2,  94,  35, 3, 0, 765, 3, 1,  800};
    vecs[2]  = '{20'h80000, 0, 0, 2,   0, 765, 3, 1, 765, 3, 1, 1530};
    vecs[3]  = '{20'h00000, 0, 1, 0,   0,   0, 0, 0,   0, 0, 0,    0};
    vecs[4]  = '{20'h4010C, 0, 0, 1, 268, 500, 0, 1,   0, 0, 0,  500};
    vecs[5]  = '{20'h5005E, 1, 0, 2,  94,  35, 3, 0, 765, 3, 1,  800};
    vecs[6]  = '{20'hC0000, 0, 1, 0,   0,   0, 0, 0,   0, 0, 0,    0};
    vecs[7]  = '{20'h10084, 0, 1, 0,   0,   0, 0, 0,   0, 0, 0,    0};
    vecs[8]  = '{20'h10083, 0, 0, 1, 131,   1, 0, 0,   0, 0, 0,    1};
    vecs[9]  = '{20'h50081, 0, 1, 0,   0,   0, 0, 0,   0, 0, 0,    0};
    vecs[10] = '{20'h20000, 0, 0, 2,   0, 129, 3, 0, 129, 3, 0,  258};

    tests = 0; fails = 0; pend_v = 1'b0; stall_mode = 1'b0;
    reset_n = 1'b0; desc_empty = 1'b1; desc_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs",
                int'({out_valid, out_data, out_sob, out_eob, out_fill, out_crc,
                      out_klarge, desc_err, in_ready, desc_rd}), 0);
    reset_n = 1'b1;

    for (int v = 0; v < 11; v++) runVector(vecs[v], v, 1'b1);

    // Reset at data byte 10 of block 1, with another descriptor queued behind.
    begin
      int cyc;
      exp_q.delete(); got_q.delete();
      desc_fifo.push_back(20'h5005E);
      desc_fifo.push_back(20'h10020);
      for (int i = 0; i < 800; i++) in_q.push_back(8'(i + 3));
      applyStimulus();
      cyc = 0;
      while (got_q.size() < 142 && cyc < 3000) begin
        runCycle();
        cyc++;
      end
      checkOutput("reset test reached block 1", int'(got_q.size() >= 142), 1);
      reset_n = 1'b0;
      runCycle();
      reset_n = 1'b1;
      #1;
      checkOutput("mid-block reset outputs",
                  int'({out_valid, out_data, out_sob, out_eob, out_fill, out_crc,
                        out_klarge, desc_err, in_ready}), 0);
      checkOutput("idle fetches queued desc after reset", int'(desc_rd), 1);
      in_q.delete();
      runVector(vecs[0], 11, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
